// File: rtl/lvds_link_trainer.sv
// lvds_link_trainer
//   Word-alignment sequencer for a multi-lane LVDS receive deserializer.
//   Every lane is compared against the training byte. A lane that does not
//   match gets a one-cycle bitslip pulse, followed by a settle window. Once a
//   lane has seen LOCK_COUNT matches in a row it is locked, and link_up follows
//   when every lane is locked. A lane that needs MAX_SLIPS slips fails the run.
//
//   Optional feature macro: LINK_TRAIN_TIMEOUT_EN
//     Defined     : a watchdog counts busy cycles. Reaching TIMEOUT_CYCLES
//                   forces FAIL with fail_lane = 0.
//     Not defined : no watchdog, and TIMEOUT_CYCLES has no effect.
module lvds_link_trainer #(
   parameter int          LANES          = 5,
   parameter logic [7:0]  TRAIN_PATTERN  = 8'h7E,
   parameter int          LOCK_COUNT     = 16,
   parameter int          SETTLE_CYCLES  = 4,
   parameter int          MAX_SLIPS      = 8,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [8*LANES-1:0]   rxdata,
   output logic [LANES-1:0]     bitslip,
   output logic [LANES-1:0]     lane_locked,
   output logic                 link_up,
   output logic                 train_busy,
   output logic                 train_fail,
   output logic [LANES-1:0]     fail_lane
);

   localparam int MC_W = $clog2(LOCK_COUNT + 1);
   localparam int SC_W = $clog2(MAX_SLIPS + 1);
   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SLIP,
      S_SETTLE,
      S_TRACK,
      S_FAIL
   } state_t;

   state_t            state;
   logic [MC_W-1:0]   match_cnt [LANES];
   logic [SC_W-1:0]   slip_cnt  [LANES];
   logic [LANES-1:0]  slip_req;
   logic [ST_W-1:0]   settle_cnt;

   // Next-cycle values evaluated during CHECK and SLIP
   logic [MC_W-1:0]   match_nxt [LANES];
   logic [SC_W-1:0]   slip_nxt  [LANES];
   logic [LANES-1:0]  lock_nxt;
   logic [LANES-1:0]  req_nxt;
   logic [LANES-1:0]  max_hit;

   logic              busy_state;
   logic              restart;
   logic              wd_expire;

   assign busy_state = (state == S_CHECK) || (state == S_SLIP) || (state == S_SETTLE);
   assign restart    = start && !busy_state;

`ifdef LINK_TRAIN_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // The watchdog expires on the edge that would make TIMEOUT_CYCLES busy cycles
   assign wd_expire = busy_state && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: cleared on an accepted start, counts (saturating) while busy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
      end else if (restart) begin
         wd_cnt <= '0;
      end else if (busy_state && (wd_cnt != WD_W'(TIMEOUT_CYCLES))) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   // Per-lane match/lock/slip bookkeeping for the current cycle
   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so
      // no path leaves a value unassigned and no latch can be inferred.
      lock_nxt = lane_locked;
      req_nxt  = slip_req;
      max_hit  = '0;
      for (int i = 0; i < LANES; i++) begin
         match_nxt[i] = match_cnt[i];
         slip_nxt[i]  = slip_cnt[i];

         // Locked lanes hold their state and ignore mismatches
         if (!lane_locked[i]) begin
            if (rxdata[8*i +: 8] == TRAIN_PATTERN) begin
               if (match_cnt[i] != MC_W'(LOCK_COUNT))
                  match_nxt[i] = match_cnt[i] + 1'b1;
               lock_nxt[i] = (match_nxt[i] == MC_W'(LOCK_COUNT));
            end else begin
               match_nxt[i] = '0;
               req_nxt[i]   = 1'b1;
            end
         end

         if (slip_req[i] && (slip_cnt[i] != SC_W'(MAX_SLIPS)))
            slip_nxt[i] = slip_cnt[i] + 1'b1;
         max_hit[i] = slip_req[i] && (slip_nxt[i] == SC_W'(MAX_SLIPS));
      end
   end

   // Training FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         slip_req    <= '0;
         settle_cnt  <= '0;
         bitslip     <= '0;
         lane_locked <= '0;
         link_up     <= 1'b0;
         train_busy  <= 1'b0;
         train_fail  <= 1'b0;
         fail_lane   <= '0;
         // NOTE: the counter arrays are state the FSM decides on, so they are
         // reset like any other register rather than left as uninitialised storage.
         for (int i = 0; i < LANES; i++) begin
            match_cnt[i] <= '0;
            slip_cnt[i]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge register values and later assignments override earlier ones.
         bitslip <= '0;

         if (wd_expire) begin
            // Timeout wins over a same-cycle lock or slip
            state      <= S_FAIL;
            slip_req   <= '0;
            train_busy <= 1'b0;
            train_fail <= 1'b1;
            link_up    <= 1'b0;
            fail_lane  <= '0;
         end else begin
            case (state)
               S_IDLE, S_TRACK, S_FAIL: begin
                  if (start) begin
                     state       <= S_CHECK;
                     slip_req    <= '0;
                     lane_locked <= '0;
                     fail_lane   <= '0;
                     link_up     <= 1'b0;
                     train_fail  <= 1'b0;
                     train_busy  <= 1'b1;
                     for (int i = 0; i < LANES; i++) begin
                        match_cnt[i] <= '0;
                        slip_cnt[i]  <= '0;
                     end
                  end else if (state == S_TRACK) begin
                     link_up <= 1'b1;
                  end
               end

               S_CHECK: begin
                  lane_locked <= lock_nxt;
                  slip_req    <= req_nxt;
                  for (int i = 0; i < LANES; i++)
                     match_cnt[i] <= match_nxt[i];
                  if (&lock_nxt) begin
                     state      <= S_TRACK;
                     train_busy <= 1'b0;
                  end else if (|req_nxt) begin
                     state   <= S_SLIP;
                     bitslip <= req_nxt;
                  end
               end

               S_SLIP: begin
                  slip_req <= '0;
                  for (int i = 0; i < LANES; i++)
                     slip_cnt[i] <= slip_nxt[i];
                  if (|max_hit) begin
                     state      <= S_FAIL;
                     fail_lane  <= max_hit;
                     train_fail <= 1'b1;
                     train_busy <= 1'b0;
                  end else begin
                     state      <= S_SETTLE;
                     settle_cnt <= '0;
                  end
               end

               S_SETTLE: begin
                  if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
                     state <= S_CHECK;
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lvds_link_trainer.sv
// tb_lvds_link_trainer
//   Directed and randomized bring-up scenarios for lvds_link_trainer. A small
//   deserializer model rotates each lane's byte once per received bitslip
//   pulse, so a lane with offset k needs exactly k slips to align. Expected
//   slip counts and lock times come from round-based arithmetic: all
//   misaligned lanes slip together once every SETTLE_CYCLES+2 cycles.
//   Build with +define+LINK_TRAIN_TIMEOUT_EN to add the watchdog scenario.
module tb_lvds_link_trainer;

   localparam int         LANES   = 5;
   localparam logic [7:0] PAT     = 8'h7E;
   localparam int         LOCK    = 16;
   localparam int         SETTLE  = 4;
   localparam int         PERIOD  = SETTLE + 2;
   localparam int         MAXSLIP = 8;

   logic               clk;
   logic               reset_n;
   logic               start;
   logic [8*LANES-1:0] rxdata;
   logic [LANES-1:0]   bitslip;
   logic [LANES-1:0]   lane_locked;
   logic               link_up;
   logic               train_busy;
   logic               train_fail;
   logic [LANES-1:0]   fail_lane;

   lvds_link_trainer #(
      .LANES          (LANES),
      .TRAIN_PATTERN  (PAT),
      .LOCK_COUNT     (LOCK),
      .SETTLE_CYCLES  (SETTLE),
      .MAX_SLIPS      (MAXSLIP),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .rxdata      (rxdata),
      .bitslip     (bitslip),
      .lane_locked (lane_locked),
      .link_up     (link_up),
      .train_busy  (train_busy),
      .train_fail  (train_fail),
      .fail_lane   (fail_lane)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Deserializer model state and observation counters
   int off        [LANES] = '{0, 0, 0, 0, 0};
   bit stuck      [LANES] = '{0, 0, 0, 0, 0};
   bit glitch     [LANES] = '{0, 0, 0, 0, 0};
   int pulses     [LANES] = '{0, 0, 0, 0, 0};
   int last_pulse [LANES] = '{-100, -100, -100, -100, -100};
   int base       [LANES];
   int exp_pulses [LANES];
   int cyc   = 0;
   int g_cnt = 0;
   int spacing_viol   = 0;
   int invariant_viol = 0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // Deserializer model: react to slip pulses, check invariants, present data
   always @(negedge clk) begin
      cyc++;
      g_cnt++;
      for (int i = 0; i < LANES; i++) begin
         if (bitslip[i]) begin
            pulses[i]++;
            if (cyc - last_pulse[i] < PERIOD) spacing_viol++;
            last_pulse[i] = cyc;
            if (!stuck[i] && !glitch[i]) off[i] = (off[i] + 7) % 8;
         end
      end
      if ((bitslip != '0) && !train_busy) invariant_viol++;
      if (link_up && train_fail) invariant_viol++;
      for (int i = 0; i < LANES; i++) begin
         if (stuck[i])
            rxdata[8*i +: 8] = 8'h00;
         else if (glitch[i] && (g_cnt % 16 == 15))
            rxdata[8*i +: 8] = 8'h00;
         else
            rxdata[8*i +: 8] = rotl(PAT, off[i]);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start pulse; returns at the negedge after the sampling edge (edge 0)
   task automatic pulse_start();
      for (int i = 0; i < LANES; i++) begin
         base[i]       = pulses[i];
         exp_pulses[i] = stuck[i] ? MAXSLIP : off[i];
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      edge_n = 0;
   endtask

   task automatic goto_edge(input int k);
      repeat (k - edge_n) @(negedge clk);
      edge_n = k;
   endtask

   task automatic check_pulses(input string tag);
      for (int i = 0; i < LANES; i++)
         check($sformatf("%s_pulses_lane%0d", tag, i), pulses[i] - base[i], exp_pulses[i]);
   endtask

   // Aligned lanes lock LOCK edges after the last slip round's settle window
   function automatic int lock_edge();
      int m;
      m = 0;
      for (int i = 0; i < LANES; i++)
         if (off[i] > m) m = off[i];
      return PERIOD * m + LOCK;
   endfunction

   initial begin
      int le;
      reset_n = 1'b0;
      start   = 1'b0;
      rxdata  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_bitslip",     bitslip,     0);
      check("rst_lane_locked", lane_locked, 0);
      check("rst_link_up",     link_up,     0);
      check("rst_busy",        train_busy,  0);
      check("rst_fail",        train_fail,  0);
      check("rst_fail_lane",   fail_lane,   0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: all lanes aligned
      off = '{0, 0, 0, 0, 0};
      pulse_start();
      check("t1_busy_e0", train_busy, 1);
      goto_edge(15);
      check("t1_locked_e15", lane_locked, 5'h00);
      goto_edge(16);
      check("t1_locked_e16", lane_locked, 5'h1F);
      check("t1_linkup_e16", link_up, 0);
      goto_edge(17);
      check("t1_linkup_e17", link_up, 1);
      check("t1_busy_e17", train_busy, 0);
      check_pulses("t1");

      // 2: lane 2 three slips off
      off = '{0, 0, 3, 0, 0};
      pulse_start();
      check("t2_linkup_cleared", link_up, 0);
      le = lock_edge();
      goto_edge(le - 1);
      check("t2_linkup_early", link_up, 0);
      goto_edge(le + 1);
      check("t2_linkup", link_up, 1);
      check("t2_locked", lane_locked, 5'h1F);
      check_pulses("t2");

      // 3: lane 0 never matches
      off   = '{0, 0, 0, 0, 0};
      stuck = '{1, 0, 0, 0, 0};
      pulse_start();
      goto_edge(PERIOD * MAXSLIP - 5);
      check("t3_fail_early", train_fail, 0);
      goto_edge(PERIOD * MAXSLIP - 4);
      check("t3_fail", train_fail, 1);
      check("t3_fail_lane", fail_lane, 5'h01);
      check("t3_linkup", link_up, 0);
      check("t3_busy", train_busy, 0);
      goto_edge(PERIOD * MAXSLIP + 10);
      check("t3_fail_held", train_fail, 1);
      check_pulses("t3");

      // 4: restart from FAIL; a start in mid-training is ignored
      stuck = '{0, 0, 0, 0, 0};
      off   = '{0, 0, 0, 0, 0};
      pulse_start();
      check("t4_fail_cleared", train_fail, 0);
      check("t4_fail_lane_cleared", fail_lane, 0);
      check("t4_busy", train_busy, 1);
      goto_edge(4);
      start = 1'b1;
      goto_edge(5);
      start = 1'b0;
      goto_edge(15);
      check("t4_locked_e15", lane_locked, 5'h00);
      goto_edge(16);
      check("t4_locked_e16", lane_locked, 5'h1F);
      goto_edge(17);
      check("t4_linkup", link_up, 1);

      // Randomized lane offsets
      for (int run = 0; run < 5; run++) begin
         for (int i = 0; i < LANES; i++) off[i] = $urandom_range(7, 0);
         pulse_start();
         le = lock_edge();
         goto_edge(le - 1);
         check($sformatf("rnd%0d_linkup_early", run), link_up, 0);
         check($sformatf("rnd%0d_busy", run), train_busy, 1);
         goto_edge(le);
         check($sformatf("rnd%0d_locked", run), lane_locked, 5'h1F);
         goto_edge(le + 1);
         check($sformatf("rnd%0d_linkup", run), link_up, 1);
         check($sformatf("rnd%0d_fail", run), train_fail, 0);
         check_pulses($sformatf("rnd%0d", run));
      end

      // 5: reset asserted while a slip pulse is high
      off = '{0, 3, 0, 0, 0};
      pulse_start();
      goto_edge(1);
      check("t5_slip_high", bitslip, 5'h02);
      reset_n = 1'b0;
      #1;
      check("t5_bitslip", bitslip, 0);
      check("t5_busy", train_busy, 0);
      check("t5_locked", lane_locked, 0);
      check("t5_linkup", link_up, 0);
      check("t5_fail", train_fail, 0);
      @(negedge clk);
      reset_n = 1'b1;
      off = '{0, 0, 0, 0, 0};
      @(negedge clk);

`ifdef LINK_TRAIN_TIMEOUT_EN
      // 6: lane 4 matches 15 of every 16 bytes; the watchdog ends the run
      glitch = '{0, 0, 0, 0, 1};
      g_cnt  = 0;
      pulse_start();
      goto_edge(63);
      check("t6_busy_e63", train_busy, 1);
      check("t6_fail_e63", train_fail, 0);
      goto_edge(64);
      check("t6_fail_e64", train_fail, 1);
      check("t6_fail_lane", fail_lane, 0);
      check("t6_linkup", link_up, 0);
      check("t6_busy_e64", train_busy, 0);
      glitch = '{0, 0, 0, 0, 0};
`endif

      check("slip_spacing", spacing_viol, 0);
      check("invariants", invariant_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
